// File: rtl/sram_port_ctrl_defs.sv
// Shared constants for the SRAM port controller.
// Opcode encoding and credit counter sizing.
package sram_port_ctrl_defs;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO between the macro capture flop and rsp_*.
// Push and pop in the same edge are legal when full or empty.
module sram_rsp_fifo
  import sram_port_ctrl_defs::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = credit_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default:            count <= count;
      endcase
    end
  end

  no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && full && !pop)
  );

endmodule

// File: rtl/sram_port_ctrl.sv
// Request sequencer for a single-port OpenRAM macro.
// Registered pin drives, two-stage read pipe, credit-limited responses.
module sram_port_ctrl
  import sram_port_ctrl_defs::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CW = credit_w(RSP_DEPTH);

  logic          rd_p1;
  logic          rd_p2;
  logic          accept;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;

  // Every read holds a credit from accept until its response pops.
  assign outstanding = CW'(rd_p1) + CW'(rd_p2) + fifo_count;
  assign req_ready   = rst0_n && (outstanding < CW'(RSP_DEPTH));
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = !fifo_empty;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
      rd_p1 <= 1'b0;
      rd_p2 <= 1'b0;
    end else begin
      csb0  <= !accept;
      web0  <= !(accept && req_we == OP_WRITE);
      rd_p1 <= accept && req_we == OP_READ;
      rd_p2 <= rd_p1;
      if (accept) begin
        addr0 <= req_addr;
      end
      if (accept && req_we == OP_WRITE) begin
        din0 <= req_wdata;
      end
    end
  end

  // dout0 is valid only at the edge where rd_p2 is set.
  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk0),
    .rst_n (rst0_n),
    .push  (rd_p2),
    .wdata (dout0),
    .pop   (rsp_ready),
    .rdata (rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  no_inflight_when_full: assert property (
    @(posedge clk0) disable iff (!rst0_n)
    fifo_full |-> !(rd_p1 || rd_p2)
  );

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Scoreboard bench for sram_port_ctrl with a behavioural macro.
// Reference: memory array, pending-response queue, credit count.
module tb_sram_port_ctrl;

  logic       clk0 = 1'b0;
  logic       rst0_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [1:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_rdata;
  logic       csb0;
  logic       web0;
  logic [3:0] addr0;
  logic [1:0] din0;
  logic [1:0] dout0;

  int total = 0;
  int bad   = 0;

  always #5 clk0 = ~clk0;

  sram_port_ctrl #(
    .DATA_WIDTH (2),
    .ADDR_WIDTH (4),
    .RSP_DEPTH  (4)
  ) dut (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  // Macro model: latch at posedge, access at negedge, X after hold.
  logic [1:0] sram [16];
  logic       l_csb = 1'b1;
  logic       l_web = 1'b1;
  logic [3:0] l_addr;
  logic [1:0] l_din;

  always @(posedge clk0) begin
    l_csb  <= csb0;
    l_web  <= web0;
    l_addr <= addr0;
    l_din  <= din0;
    #1 dout0 = 'x;
  end

  always @(negedge clk0) begin
    if (!l_csb) begin
      if (!l_web) begin
        sram[l_addr] = l_din;
      end else begin
        #2 dout0 = sram[l_addr];
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [1:0] d;
    int         rdy;
  } exp_t;

  exp_t       q[$];
  logic [1:0] ref_mem [16];
  int         outst    = 0;
  int         edge_cnt = 0;
  int         npop     = 0;
  logic       exp_csb  = 1'b1;
  logic       exp_web  = 1'b1;
  logic [3:0] exp_addr = '0;
  logic [1:0] exp_din  = '0;

  always @(posedge clk0) edge_cnt++;

  always @(negedge clk0) begin
    logic exp_v;
    logic exp_rdy;
    if (!rst0_n) begin
      chk("rst_csb0", 32'(csb0), 1);
      chk("rst_web0", 32'(web0), 1);
      chk("rst_addr0", 32'(addr0), 0);
      chk("rst_din0", 32'(din0), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      q.delete();
      outst    = 0;
      exp_csb  = 1'b1;
      exp_web  = 1'b1;
      exp_addr = '0;
      exp_din  = '0;
    end else begin
      chk("csb0", 32'(csb0), 32'(exp_csb));
      chk("web0", 32'(web0), 32'(exp_web));
      chk("addr0", 32'(addr0), 32'(exp_addr));
      chk("din0", 32'(din0), 32'(exp_din));
      exp_rdy = (outst < 4);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_v = (q.size() > 0) && (q[0].rdy <= edge_cnt);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].d));
        if (rsp_ready) begin
          void'(q.pop_front());
          outst--;
          npop++;
        end
      end
      if (req_valid && exp_rdy) begin
        exp_csb  = 1'b0;
        exp_web  = !req_we;
        exp_addr = req_addr;
        if (req_we) begin
          exp_din           = req_wdata;
          ref_mem[req_addr] = req_wdata;
        end else begin
          q.push_back('{d: ref_mem[req_addr], rdy: edge_cnt + 3});
          outst++;
        end
      end else begin
        exp_csb = 1'b1;
        exp_web = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input logic we, input logic [3:0] a,
                       input logic [1:0] d, output int waits);
    bit got;
    got       = 1'b0;
    waits     = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!got && waits < 64) begin
      @(negedge clk0);
      got = req_ready;
      step();
      if (!got) waits++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no accept want accept");
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n         = 0;
    rsp_ready = 1'b1;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int w;
    int stalls;
    int acc;
    int p0;
    for (int i = 0; i < 16; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    rst0_n    = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'd3;
    req_wdata = 2'd1;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk0);
    #1;
    rst0_n    = 1'b1;
    req_valid = 1'b0;
    @(negedge clk0);
    chk("ready_after_rst", 32'(req_ready), 1);
    step();
    rsp_ready = 1'b1;

    issue(1'b1, 4'd5, 2'b10, w);
    issue(1'b0, 4'd5, 2'b00, w);
    idle(4);
    chk("wr_rd_rsp", 32'(npop), 1);

    for (int a = 0; a < 16; a++) begin
      issue(1'b1, 4'(a), 2'(a), w);
    end
    stalls = 0;
    p0     = npop;
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, 4'(a), 2'b00, w);
      stalls += w;
    end
    chk("stream_stall", 32'(stalls), 0);
    idle(6);
    chk("stream_rsp", 32'(npop - p0), 16);

    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    acc       = 0;
    repeat (8) begin
      @(negedge clk0);
      if (req_ready) acc++;
      step();
      req_addr = 4'($urandom);
    end
    chk("bp_accepts", 32'(acc), 4);
    @(negedge clk0);
    chk("bp_ready", 32'(req_ready), 0);
    step();
    req_valid = 1'b0;
    p0        = npop;
    drain();
    chk("bp_rsp", 32'(npop - p0), 4);
    issue(1'b0, 4'd7, 2'b00, w);
    chk("bp_resume", 32'(w), 0);
    drain();

    for (int c = 0; c < 800; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 4'($urandom);
      req_wdata = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0;
    drain();

    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(1'b0, 4'(k), 2'b00, w);
    end
    rst0_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_csb0", 32'(csb0), 1);
    chk("midrst_web0", 32'(web0), 1);
    idle(2);
    rst0_n    = 1'b1;
    rsp_ready = 1'b1;
    p0        = npop;
    idle(10);
    chk("midrst_no_stale", 32'(npop - p0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
